sobel_stream_filter: RTL and testbench

- Streaming 3x3 Sobel edge filter for the camera gray path; sits between the gray converter and the frame-buffer writer.
- Generalises the single-direction Sobel stage:
  - parametrised pixel width and line length
  - internal line buffers and frame/line counters
  - four magnitude modes, latched per frame
  - registered 2-cycle pipeline
  - threshold edge flag

---
 rtl/sobel_stream_filter_if.sv | 27 ++
 rtl/sobel_stream_filter.sv | 196 +++++++++++++++++++
 tb/tb_sobel_stream_filter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_stream_filter_if.sv
// Pixel stream bundle for sobel_stream_filter: frame/pixel valid, gray data,
// mode/threshold controls, and the filtered output stream.
interface sobel_stream_filter_if #(
  parameter int unsigned PIX_W = 12
);
  logic             iFVAL;
  logic             iDVAL;
  logic [PIX_W-1:0] iGRAY;
  logic [1:0]       iMODE;
  logic [PIX_W-1:0] iTHRESH;
  logic             oDVAL;
  logic [PIX_W-1:0] oPIX;
  logic             oWIN_VALID;
  logic             oEDGE;

  // Source side: drives the gray stream, receives filtered pixels.
  modport master (
    output iFVAL, iDVAL, iGRAY, iMODE, iTHRESH,
    input  oDVAL, oPIX, oWIN_VALID, oEDGE
  );

  // Filter side.
  modport slave (
    input  iFVAL, iDVAL, iGRAY, iMODE, iTHRESH,
    output oDVAL, oPIX, oWIN_VALID, oEDGE
  );
endinterface

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter with internal line buffers.
// Two-stage registered pipeline: stage 1 holds |Gx|,|Gy|, stage 2 the outputs.
// Optional macro SOBEL_BINARIZE_EN: valid windows output all-ones/zero against
// iTHRESH instead of the clamped magnitude.
module sobel_stream_filter #(
  parameter int unsigned PIX_W     = 12,
  parameter int unsigned LINE_W    = 640,
  parameter int unsigned MAG_SHIFT = 4
) (
  input logic                 iCLK,
  input logic                 iRST_N,
  sobel_stream_filter_if.slave bus
);
  localparam int unsigned COL_W = $clog2(LINE_W);
  localparam int unsigned SW    = PIX_W + 5;

  typedef logic [PIX_W-1:0]      pix_t;
  typedef logic signed [SW-1:0]  s_t;
  typedef logic [SW-1:0]         u_t;

  localparam u_t PIX_MAX = u_t'({PIX_W{1'b1}});

  // Frame tracking
  logic             fval_prev;
  logic             frame_on;
  logic [1:0]       mode_q;
  logic             fval_rise;
  logic             accept;
  logic [1:0]       mode_eff;
  logic [COL_W-1:0] col;
  logic [1:0]       rows_done;
  logic             win_valid;

  // Line buffers and window
  pix_t lb1 [LINE_W];
  pix_t lb2 [LINE_W];
  pix_t up1, up2;
  pix_t win  [3][3];
  pix_t nwin [3][3];

  // Arithmetic
  s_t gx, gy;
  u_t ax, ay;

  // Stage 1
  u_t         s1_ax, s1_ay;
  logic       s1_win, s1_dval;
  pix_t       s1_pix;
  logic [1:0] s1_mode;

  // Stage 2 combinational
  u_t   mag, shifted;
  pix_t clamped, win_pix;

  function automatic s_t zx(input pix_t p);
    return s_t'({5'b0, p});
  endfunction

  // fval_prev resets high so a frame already running at reset release is not
  // mistaken for a fresh rise; the block then waits for iFVAL to drop and rise.
  assign fval_rise = bus.iFVAL & ~fval_prev;
  assign accept    = bus.iFVAL & bus.iDVAL & (frame_on | fval_rise);
  assign mode_eff  = fval_rise ? bus.iMODE : mode_q;
  assign win_valid = (rows_done == 2'd2) && (col >= COL_W'(2));

  // Frame start detection and per-frame mode latch
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      fval_prev <= 1'b1;
      frame_on  <= 1'b0;
      mode_q    <= 2'b00;
    end else begin
      fval_prev <= bus.iFVAL;
      frame_on  <= bus.iFVAL & (frame_on | fval_rise);
      if (fval_rise) mode_q <= bus.iMODE;
    end
  end

  // Column / row position of the accepted pixel
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      col       <= '0;
      rows_done <= '0;
    end else if (!bus.iFVAL) begin
      col       <= '0;
      rows_done <= '0;
    end else if (accept) begin
      if (col == COL_W'(LINE_W - 1)) begin
        col <= '0;
        if (rows_done != 2'd2) rows_done <= rows_done + 2'd1;
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Line-buffer read of the pixels one and two lines above
  always_comb begin
    up1 = lb1[col];
    up2 = lb2[col];
  end

  // Line-buffer write; contents are deliberately not reset
  always_ff @(posedge iCLK) begin
    if (accept) begin
      lb1[col] <= bus.iGRAY;
      lb2[col] <= up1;
    end
  end

  // Window after shifting in the accepted column (row 2 newest, col 2 newest)
  always_comb begin
    for (int unsigned r = 0; r < 3; r++) begin
      nwin[r][0] = win[r][1];
      nwin[r][1] = win[r][2];
      nwin[r][2] = '0;
    end
    nwin[0][2] = up2;
    nwin[1][2] = up1;
    nwin[2][2] = bus.iGRAY;
  end

  // Window register shift on each accepted pixel
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int unsigned r = 0; r < 3; r++)
        for (int unsigned c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else if (accept) begin
      win <= nwin;
    end
  end

  // Sobel gradients of the window that includes the accepted pixel
  always_comb begin
    gx = (zx(nwin[0][2]) + (zx(nwin[1][2]) <<< 1) + zx(nwin[2][2]))
       - (zx(nwin[0][0]) + (zx(nwin[1][0]) <<< 1) + zx(nwin[2][0]));
    gy = (zx(nwin[2][0]) + (zx(nwin[2][1]) <<< 1) + zx(nwin[2][2]))
       - (zx(nwin[0][0]) + (zx(nwin[0][1]) <<< 1) + zx(nwin[0][2]));
    ax = gx[SW-1] ? u_t'(-gx) : u_t'(gx);
    ay = gy[SW-1] ? u_t'(-gy) : u_t'(gy);
  end

  // Stage 1: gradient magnitudes, validity and passthrough pixel
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s1_ax   <= '0;
      s1_ay   <= '0;
      s1_win  <= 1'b0;
      s1_dval <= 1'b0;
      s1_pix  <= '0;
      s1_mode <= 2'b00;
    end else begin
      s1_ax   <= ax;
      s1_ay   <= ay;
      s1_win  <= accept & win_valid;
      s1_dval <= accept;
      s1_pix  <= bus.iGRAY;
      s1_mode <= mode_eff;
    end
  end

  // Magnitude select, shift and clamp
  always_comb begin
    case (s1_mode)
      2'b00:   mag = s1_ax;
      2'b01:   mag = s1_ay;
      2'b10:   mag = s1_ax + s1_ay;
      default: mag = (s1_ax > s1_ay) ? s1_ax : s1_ay;
    endcase
    shifted = mag >> MAG_SHIFT;
    clamped = (shifted > PIX_MAX) ? '1 : shifted[PIX_W-1:0];
`ifdef SOBEL_BINARIZE_EN
    win_pix = (clamped >= bus.iTHRESH) ? '1 : '0;
`else
    win_pix = clamped;
`endif
  end

  // Stage 2: registered outputs, zeroed on idle cycles
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      bus.oDVAL      <= 1'b0;
      bus.oPIX       <= '0;
      bus.oWIN_VALID <= 1'b0;
      bus.oEDGE      <= 1'b0;
    end else begin
      bus.oDVAL      <= s1_dval;
      bus.oWIN_VALID <= s1_win;
      bus.oEDGE      <= s1_win & (clamped >= bus.iTHRESH);
      if (!s1_dval)    bus.oPIX <= '0;
      else if (s1_win) bus.oPIX <= win_pix;
      else             bus.oPIX <= s1_pix;
    end
  end
endmodule

// File: tb/tb_sobel_stream_filter.sv
// Randomised bench for sobel_stream_filter against a raster-image reference model.
module tb_sobel_stream_filter;
  localparam int unsigned PW = 12;
  localparam int unsigned LW = 16;
  localparam int unsigned NR = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fval = 1'b0, dval = 1'b0;
  logic [11:0] gray = '0, thresh = 12'h200;
  logic [1:0] mode = 2'b00;

  always #5 clk = ~clk;

  sobel_stream_filter_if #(.PIX_W(PW)) bus4 ();
  sobel_stream_filter_if #(.PIX_W(PW)) bus0 ();

  assign bus4.iFVAL = fval;   assign bus0.iFVAL = fval;
  assign bus4.iDVAL = dval;   assign bus0.iDVAL = dval;
  assign bus4.iGRAY = gray;   assign bus0.iGRAY = gray;
  assign bus4.iMODE = mode;   assign bus0.iMODE = mode;
  assign bus4.iTHRESH = thresh; assign bus0.iTHRESH = thresh;

  sobel_stream_filter #(.PIX_W(PW), .LINE_W(LW), .MAG_SHIFT(4)) dut4 (
    .iCLK(clk), .iRST_N(rst_n), .bus(bus4));
  sobel_stream_filter #(.PIX_W(PW), .LINE_W(LW), .MAG_SHIFT(0)) dut0 (
    .iCLK(clk), .iRST_N(rst_n), .bus(bus0));

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    logic        win;
    logic [11:0] p4, p0;
    logic        e4, e0;
  } exp_t;

  exp_t q[$];
  int   img [64][LW];
  logic m_prev = 1'b1;
  logic m_on = 1'b0;
  logic [1:0] m_mode = 2'b00;
  int   m_idx = 0;

  function automatic int exp_mag(int r, int c, logic [1:0] md);
    int gx, gy, ax, ay;
    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    case (md)
      2'b00:   return ax;
      2'b01:   return ay;
      2'b10:   return ax + ay;
      default: return (ax > ay) ? ax : ay;
    endcase
  endfunction

  function automatic int shclamp(int m, int sh);
    int v;
    v = m >> sh;
    return (v > 4095) ? 4095 : v;
  endfunction

  function automatic logic [11:0] win_out(int v);
`ifdef SOBEL_BINARIZE_EN
    return (v >= int'(thresh)) ? 12'hFFF : 12'h000;
`else
    return v[11:0];
`endif
  endfunction

  task automatic model_reset();
    q.delete();
    m_prev = 1'b1;
    m_on   = 1'b0;
    m_mode = 2'b00;
    m_idx  = 0;
  endtask

  task automatic model_step();
    logic rise, acc;
    int   r, c, m, v4, v0;
    exp_t e;
    rise = fval && !m_prev;
    acc  = fval && dval && (m_on || rise);
    if (rise) m_mode = mode;
    if (acc) begin
      r = m_idx / LW;
      c = m_idx % LW;
      if (r < 64) img[r][c] = int'(gray);
      e.due = cyc + 2;
      e.win = (r >= 2) && (c >= 2);
      if (e.win) begin
        m  = exp_mag(r, c, m_mode);
        v4 = shclamp(m, 4);
        v0 = shclamp(m, 0);
        e.p4 = win_out(v4);
        e.p0 = win_out(v0);
        e.e4 = (v4 >= int'(thresh));
        e.e0 = (v0 >= int'(thresh));
      end else begin
        e.p4 = gray; e.p0 = gray; e.e4 = 1'b0; e.e0 = 1'b0;
      end
      q.push_back(e);
      m_idx++;
    end
    if (!fval) m_idx = 0;
    m_on   = fval && (m_on || rise);
    m_prev = fval;
  endtask

  // ---------------- compare process ----------------
  int f_out = 0, f_win = 0, f_edge4 = 0, f_full0 = 0;

  always @(negedge clk) begin
    exp_t e;
    logic [14:0] a4, a0;
    a4 = {bus4.oDVAL, bus4.oWIN_VALID, bus4.oEDGE, bus4.oPIX};
    a0 = {bus0.oDVAL, bus0.oWIN_VALID, bus0.oEDGE, bus0.oPIX};
    if (!rst_n) begin
      chk("reset_outputs", {a4, a0}, '0);
    end else if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("out_shift4", a4, {1'b1, e.win, e.e4, e.p4});
      chk("out_shift0", a0, {1'b1, e.win, e.e0, e.p0});
      f_out++;
      if (bus4.oWIN_VALID) f_win++;
      if (bus4.oEDGE) f_edge4++;
      if (bus0.oWIN_VALID && bus0.oPIX == 12'hFFF) f_full0++;
    end else begin
      if (q.size() > 0 && q[0].due < cyc) begin
        chk("missed_output_due", q[0].due, cyc);
        void'(q.pop_front());
      end
      chk("idle_outputs", {a4, a0}, '0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle(input logic f, input logic d, input logic [11:0] g);
    @(posedge clk);
    #1;
    fval = f; dval = d; gray = g;
    model_step();
  endtask

  function automatic logic [11:0] pix(int kind, int r, int c);
    case (kind)
      0:       return 12'h800;
      1:       return (c < int'(LW/2)) ? 12'h000 : 12'hFFF;
      2:       return (r < int'(NR/2)) ? 12'h000 : 12'hFFF;
      default: return 12'($urandom);
    endcase
  endfunction

  task automatic idle(int n);
    repeat (n) cycle(1'b0, 1'($urandom_range(1)), 12'($urandom));
  endtask

  task automatic run_frame(input int kind, input logic [1:0] md, input int gap,
                           input int sw_row, input logic [1:0] md2);
    f_out = 0; f_win = 0; f_edge4 = 0; f_full0 = 0;
    mode = md;
    for (int r = 0; r < int'(NR); r++) begin
      for (int c = 0; c < int'(LW); c++) begin
        while (int'($urandom_range(99)) < gap) cycle(1'b1, 1'b0, 12'($urandom));
        if (r == sw_row && c == 0) mode = md2;
        cycle(1'b1, 1'b1, pix(kind, r, c));
      end
    end
    idle(5);
  endtask

  initial begin
    // Pin the model with hand-computed windows.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        img[r][c] = (c == 2) ? 4095 : 0;
    chk("pin_vstep_gx", exp_mag(2, 2, 2'b00), 16380);
    chk("pin_vstep_gy", exp_mag(2, 2, 2'b01), 0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        img[r][c] = (r == 2) ? 4095 : 0;
    chk("pin_hstep_max", exp_mag(2, 2, 2'b11), 16380);
    chk("pin_shift4", shclamp(16380, 4), 1023);
    chk("pin_shift0", shclamp(16380, 0), 4095);

    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);

    // Flat field: every window zero, borders pass through.
    run_frame(0, 2'b00, 0, -1, 2'b00);
    chk("flat_outputs", f_out, NR*LW);
    chk("flat_windows", f_win, (NR-2)*(LW-2));
    chk("flat_edges", f_edge4, 0);

    // Vertical step, |Gx| then |Gy|.
    run_frame(1, 2'b00, 0, -1, 2'b00);
    chk("vstep_gx_edges", f_edge4, 2*(NR-2));
    run_frame(1, 2'b01, 0, -1, 2'b01);
    chk("vstep_gy_edges", f_edge4, 0);

    // Horizontal step, sum and max modes; unshifted instance clamps.
    run_frame(2, 2'b10, 0, -1, 2'b10);
    chk("hstep_sum_edges", f_edge4, 2*(LW-2));
    chk("hstep_sum_clamp0", f_full0, 2*(LW-2));
    run_frame(2, 2'b11, 0, -1, 2'b11);
    chk("hstep_max_edges", f_edge4, 2*(LW-2));

    // Random images with gaps; mode changed mid-frame only applies next frame.
    thresh = 12'h080;
    run_frame(3, 2'b00, 30, 4, 2'b01);
    chk("rand_gap_outputs", f_out, NR*LW);
    run_frame(3, 2'b01, 30, -1, 2'b01);
    thresh = 12'($urandom);
    run_frame(3, 2'b10, 20, 3, 2'b00);
    run_frame(3, 2'b11, 20, -1, 2'b11);
    thresh = 12'h200;

    // Reset pulse mid-frame, remainder of frame ignored.
    mode = 2'b10;
    for (int r = 0; r < int'(NR); r++) begin
      for (int c = 0; c < int'(LW); c++) begin
        cycle(1'b1, 1'b1, 12'($urandom));
        if (r == 3 && c == 5) begin
          @(posedge clk);
          #1 rst_n = 1'b0;
          model_reset();
          #1 chk("reset_immediate", {bus4.oDVAL, bus4.oPIX, bus4.oEDGE}, '0);
          cycle(1'b1, 1'b1, 12'($urandom));
          cycle(1'b1, 1'b1, 12'($urandom));
          #1 rst_n = 1'b1;
          f_out = 0;
        end
      end
    end
    idle(5);
    chk("post_reset_no_output", f_out, 0);
    run_frame(3, 2'b00, 10, -1, 2'b00);
    chk("post_reset_outputs", f_out, NR*LW);
    chk("post_reset_windows", f_win, (NR-2)*(LW-2));

    // Frame cut short mid-line: in-flight pixels still emerge, next frame clean.
    mode = 2'b11;
    for (int i = 0; i < int'(LW*3 + 7); i++) cycle(1'b1, 1'b1, 12'($urandom));
    idle(5);
    run_frame(3, 2'b01, 0, -1, 2'b01);

    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
